// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder.
//   - SEG_0..SEG_9, SEG_BLANK: active-high segment patterns, bit 0 = a ... bit 6 = g
//   - CODE_INVALID: digit code reported for patterns outside the decode table
//   - slot_t: one captured digit position {code, blank, err}
//   - state_e: output-side frame state
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_INVALID = 4'hF;

  typedef struct packed {
    logic [3:0] code;
    logic       blank;
    logic       err;
  } slot_t;

  typedef enum logic [0:0] {
    EMPTY,
    HOLD
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to digit-code decoder.
//   seg   : segment pattern, bit 0 = a ... bit 6 = g, 1 = lit
//   code  : 0..9 for a recognised digit, 0 for a dark position, CODE_INVALID otherwise
//   blank : position is dark (seg == 0)
//   err   : pattern is neither a digit nor dark
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       blank,
  output logic       err
);

  always_comb begin
    code  = CODE_INVALID;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: begin
        code  = 4'd0;
        blank = 1'b1;
      end
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment display bus.
// Samples seg/dig_sel, debounces each {seg, dig_sel} pattern, decodes stable patterns into
// per-position slots and, once every position has been seen, presents the whole frame on a
// valid/ready interface.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   seg        : segment bus, bit 0 = a ... bit 6 = g, 1 = lit
//   dig_sel    : one-hot digit enable, bit i = position i
//   out_ready  : consumer accepts the presented frame
//   out_valid  : frame available
//   out_digits : digit i in [4i+3:4i], 0..9 or 4'hF for an invalid pattern
//   out_blank  : bit i = position i was dark
//   out_err    : bit i = position i carried an undecodable pattern
//   overrun    : sticky, a completed frame was dropped while the previous one was unacknowledged
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_blank,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    overrun
);

  localparam logic [3:0]            StableMax = 4'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AllSeen   = '1;

  // ---------------------------------------------------------------------------
  // Sample stage and stability counter
  // ---------------------------------------------------------------------------
  logic [6:0]            seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0] sel_q, prev_sel_q;
  logic [3:0]            stab_q, stab_d;
  logic                  accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= '0;
      sel_q      <= '0;
      prev_seg_q <= '0;
      prev_sel_q <= '0;
      stab_q     <= '0;
    end else begin
      seg_q      <= seg;
      sel_q      <= dig_sel;
      prev_seg_q <= seg_q;
      prev_sel_q <= sel_q;
      stab_q     <= stab_d;
    end
  end

  always_comb begin
    if ({seg_q, sel_q} == {prev_seg_q, prev_sel_q}) begin
      stab_d = (stab_q >= StableMax) ? StableMax : stab_q + 4'd1;
    end else begin
      stab_d = 4'd1;
    end
  end

  // Fires only on the transition into saturation, so a held pattern is accepted once.
  // A zero or multi-hot select keeps counting but is never accepted.
  assign accept = (stab_d == StableMax) && (stab_q != StableMax) && $onehot(sel_q);

  // ---------------------------------------------------------------------------
  // Decode and slot collection
  // ---------------------------------------------------------------------------
  logic [3:0] dec_code;
  logic       dec_blank;
  logic       dec_err;

  seg7_pattern_decode u_decode (
    .seg   (seg_q),
    .code  (dec_code),
    .blank (dec_blank),
    .err   (dec_err)
  );

  slot_t                 slot_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic                  frame_done;

  // Completion is judged on the registered mask, i.e. the cycle after the last slot write.
  assign frame_done = (seen_q == AllSeen);

  always_comb begin
    seen_d = frame_done ? '0 : seen_q;
    if (accept) begin
      seen_d = seen_d | sel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      seen_q <= seen_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (accept && sel_q[i]) begin
          slot_q[i] <= '{code: dec_code, blank: dec_blank, err: dec_err};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   load_out;
  logic   drop_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (frame_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A frame completing during the handshake replaces the old one and keeps us in HOLD.
        if (out_ready && !frame_done) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    load_out   = 1'b0;
    drop_frame = 1'b0;
    case (state_q)
      EMPTY: load_out = frame_done;
      HOLD: begin
        load_out   = frame_done && out_ready;
        drop_frame = frame_done && !out_ready;
      end
      default: ;
    endcase
  end

  assign out_valid = (state_q == HOLD);

  // ---------------------------------------------------------------------------
  // Presented frame registers
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   err_q;
  logic                    overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q  <= '0;
      blank_q   <= '0;
      err_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (load_out) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          digits_q[4*i +: 4] <= slot_q[i].code;
          blank_q[i]         <= slot_q[i].blank;
          err_q[i]           <= slot_q[i].err;
        end
      end
      if (drop_frame) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign out_digits = digits_q;
  assign out_blank  = blank_q;
  assign out_err    = err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=3).
// The reference model tracks run lengths of identical pin patterns and the frame hand-off
// rules at the level of whole transactions; directed scenarios also check literal values.
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic [ND-1:0] dig_sel;
  logic          out_ready;
  logic          out_valid;
  logic [4*ND-1:0] out_digits;
  logic [ND-1:0] out_blank;
  logic [ND-1:0] out_err;
  logic          overrun;

  int n_checks = 0;
  int n_bad    = 0;

  seg_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_digits (out_digits),
    .out_blank  (out_blank),
    .out_err    (out_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int            m_run;
  bit            m_have_last;
  logic [6:0]    m_last_seg;
  logic [ND-1:0] m_last_sel;
  bit            m_pend;
  int            m_pend_idx;
  logic [3:0]    m_pend_code;
  logic          m_pend_blank, m_pend_err;
  logic [ND-1:0] m_seen;
  logic [3:0]    m_slot_code [ND];
  logic          m_slot_blank [ND];
  logic          m_slot_err [ND];
  logic          m_valid;
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0] m_blank, m_err;
  logic          m_ovr;

  function automatic void m_decode(input logic [6:0] s, output logic [3:0] c,
                                   output logic b, output logic e);
    c = 4'hF;
    b = 1'b0;
    e = 1'b1;
    if (s == 7'h00) begin
      c = 4'h0;
      b = 1'b1;
      e = 1'b0;
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (seg_tbl[k] == s) begin
          c = 4'(k);
          e = 1'b0;
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_run       = 0;
    m_have_last = 0;
    m_pend      = 0;
    m_seen      = '0;
    for (int i = 0; i < ND; i++) begin
      m_slot_code[i]  = '0;
      m_slot_blank[i] = 1'b0;
      m_slot_err[i]   = 1'b0;
    end
    m_valid  = 1'b0;
    m_digits = '0;
    m_blank  = '0;
    m_err    = '0;
    m_ovr    = 1'b0;
  endtask

  // One rising edge: frame hand-off on the mask as it stood, then the write accepted one
  // cycle ago, then classify the pins present during the cycle that just ended.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    if (m_seen == '1) begin
      m_seen = '0;
      if (!m_valid || out_ready) begin
        for (int i = 0; i < ND; i++) begin
          m_digits[4*i +: 4] = m_slot_code[i];
          m_blank[i]         = m_slot_blank[i];
          m_err[i]           = m_slot_err[i];
        end
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (m_pend) begin
      m_slot_code[m_pend_idx]  = m_pend_code;
      m_slot_blank[m_pend_idx] = m_pend_blank;
      m_slot_err[m_pend_idx]   = m_pend_err;
      m_seen[m_pend_idx]       = 1'b1;
    end
    if (m_have_last && seg == m_last_seg && dig_sel == m_last_sel) m_run++;
    else m_run = 1;
    m_last_seg  = seg;
    m_last_sel  = dig_sel;
    m_have_last = 1;
    m_pend = (m_run == SC) && ($countones(dig_sel) == 1);
    if (m_pend) begin
      for (int i = 0; i < ND; i++) if (dig_sel[i]) m_pend_idx = i;
      m_decode(seg, m_pend_code, m_pend_blank, m_pend_err);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [6:0] s, input logic [ND-1:0] d, input int n);
    seg     = s;
    dig_sel = d;
    repeat (n) tick();
  endtask

  task automatic ack_pulse();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; seg = '0; dig_sel = '0; out_ready = 1'b0;
    model_reset();
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if ({out_digits, out_blank, out_err, overrun} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b want all zero",
               out_digits, out_blank, out_err, overrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    drive(7'h06, 4'b0001, 5);
    drive(7'h4F, 4'b0010, 5);
    drive(7'h66, 4'b0100, 5);
    drive(7'h7F, 4'b1000, 4);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_latency_early: got valid=%b want 0", out_valid);
    end
    tick();
    n_checks++;
    if ({out_valid, out_digits, out_blank, out_err} !== {1'b1, 16'h8431, 4'b0000, 4'b0000}) begin
      n_bad++;
      $display("FAIL basic_frame: got v=%b d=%h b=%b e=%b want v=1 d=8431 b=0000 e=0000",
               out_valid, out_digits, out_blank, out_err);
    end
    drive(7'h00, 4'b0000, 4);
    n_checks++;
    if ({out_valid, out_digits} !== {1'b1, 16'h8431} ||
        {out_valid, out_digits} !== {m_valid, m_digits}) begin
      n_bad++;
      $display("FAIL basic_hold: got v=%b d=%h want v=1 d=8431", out_valid, out_digits);
    end
  endtask

  task automatic test_overrun();
    drive(7'h5D, 4'b0001, 5);
    drive(7'h6F, 4'b0010, 5);
    drive(7'h07, 4'b0100, 5);
    drive(7'h3F, 4'b1000, 5);
    n_checks++;
    if ({overrun, out_valid, out_digits, out_err} !== {1'b1, 1'b1, 16'h8431, 4'b0000}) begin
      n_bad++;
      $display("FAIL overrun_drop: got ovr=%b v=%b d=%h e=%b want ovr=1 v=1 d=8431 e=0000",
               overrun, out_valid, out_digits, out_err);
    end
    ack_pulse();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL overrun_ack: got valid=%b want 0", out_valid);
    end
    drive(7'h3F, 4'b0001, 5);
    drive(7'h06, 4'b0010, 5);
    drive(7'h5B, 4'b0100, 5);
    drive(7'h4F, 4'b1000, 5);
    n_checks++;
    if ({out_valid, out_digits, overrun} !== {1'b1, 16'h3210, 1'b1} ||
        {out_valid, out_digits, out_blank, out_err, overrun} !==
        {m_valid, m_digits, m_blank, m_err, m_ovr}) begin
      n_bad++;
      $display("FAIL overrun_next: got v=%b d=%h ovr=%b want v=1 d=3210 ovr=1",
               out_valid, out_digits, overrun);
    end
  endtask

  task automatic test_simultaneous();
    logic ovr_before;
    ovr_before = overrun;
    drive(7'h6D, 4'b0001, 5);
    drive(7'h7D, 4'b0010, 5);
    drive(7'h07, 4'b0100, 5);
    drive(7'h7F, 4'b1000, 4);
    n_checks++;
    if ({out_valid, out_digits} !== {1'b1, 16'h3210}) begin
      n_bad++;
      $display("FAIL simul_before: got v=%b d=%h want v=1 d=3210", out_valid, out_digits);
    end
    ack_pulse();
    n_checks++;
    if ({out_valid, out_digits, overrun} !== {1'b1, 16'h8765, ovr_before}) begin
      n_bad++;
      $display("FAIL simul_replace: got v=%b d=%h ovr=%b want v=1 d=8765 ovr=%b",
               out_valid, out_digits, overrun, ovr_before);
    end
    ack_pulse();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL simul_ack: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_glitch();
    drive(7'h06, 4'b0010, 5);
    drive(7'h06, 4'b0100, 5);
    drive(7'h06, 4'b1000, 5);
    for (int k = 0; k < 6; k++) begin
      drive(k[0] ? 7'h06 : 7'h3F, 4'b0001, 2);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL glitch_no_accept: got valid=%b want 0", out_valid);
    end
    drive(7'h5B, 4'b0001, 3);
    drive(7'h00, 4'b0000, 3);
    n_checks++;
    if ({out_valid, out_digits, out_err} !== {1'b1, 16'h1112, 4'b0000}) begin
      n_bad++;
      $display("FAIL glitch_capture: got v=%b d=%h e=%b want v=1 d=1112 e=0000",
               out_valid, out_digits, out_err);
    end
    ack_pulse();
  endtask

  task automatic test_blank_invalid();
    drive(7'h3F, 4'b0001, 5);
    drive(7'h06, 4'b0010, 5);
    drive(7'h00, 4'b0100, 5);
    drive(7'h41, 4'b1000, 5);
    n_checks++;
    if ({out_valid, out_blank, out_err} !== {1'b1, 4'b0100, 4'b1000}) begin
      n_bad++;
      $display("FAIL blank_err_flags: got v=%b b=%b e=%b want v=1 b=0100 e=1000",
               out_valid, out_blank, out_err);
    end
    n_checks++;
    if (out_digits !== 16'hF010) begin
      n_bad++; $display("FAIL blank_err_digits: got %h want f010", out_digits);
    end
    ack_pulse();
  endtask

  task automatic test_select_faults();
    drive(7'h06, 4'b0010, 5);
    drive(7'h4F, 4'b0100, 5);
    drive(7'h66, 4'b1000, 5);
    drive(7'h3F, 4'b0000, 10);
    drive(7'h7F, 4'b0011, 10);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL selfault_no_write: got valid=%b want 0", out_valid);
    end
    drive(7'h6D, 4'b0001, 5);
    drive(7'h00, 4'b0000, 2);
    n_checks++;
    if ({out_valid, out_digits} !== {1'b1, 16'h4315}) begin
      n_bad++;
      $display("FAIL selfault_frame: got v=%b d=%h want v=1 d=4315", out_valid, out_digits);
    end
    ack_pulse();
  endtask

  task automatic test_reset_mid_frame();
    drive(7'h3F, 4'b0001, 5);
    drive(7'h06, 4'b0010, 5);
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({out_valid, out_digits, out_blank, out_err, overrun} !== '0) begin
      n_bad++;
      $display("FAIL midreset_clear: got v=%b d=%h b=%b e=%b ovr=%b want all zero",
               out_valid, out_digits, out_blank, out_err, overrun);
    end
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    drive(7'h5B, 4'b0100, 5);
    drive(7'h4F, 4'b1000, 5);
    drive(7'h00, 4'b0000, 3);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_partial: got valid=%b want 0", out_valid);
    end
    drive(7'h66, 4'b0001, 5);
    drive(7'h6D, 4'b0010, 5);
    n_checks++;
    if ({out_valid, out_digits, overrun} !== {1'b1, 16'h3254, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset_fresh: got v=%b d=%h ovr=%b want v=1 d=3254 ovr=0",
               out_valid, out_digits, overrun);
    end
    ack_pulse();
  endtask

  task automatic test_random();
    logic [6:0]    s;
    logic [ND-1:0] d;
    int            hold;
    int            pick;
    for (int seg_n = 0; seg_n < 200; seg_n++) begin
      pick = $urandom_range(0, 12);
      if (pick < 10) s = seg_tbl[pick];
      else if (pick == 10) s = 7'h00;
      else s = 7'($urandom);
      if ($urandom_range(0, 99) < 85) d = 4'(1 << $urandom_range(0, ND - 1));
      else d = 4'($urandom);
      hold = $urandom_range(1, 6);
      seg = s;
      dig_sel = d;
      for (int c = 0; c < hold; c++) begin
        out_ready = ($urandom_range(0, 3) == 0);
        tick();
        n_checks++;
        if ({out_valid, out_digits, out_blank, out_err, overrun} !==
            {m_valid, m_digits, m_blank, m_err, m_ovr}) begin
          n_bad++;
          $display("FAIL random_cmp: got v=%b d=%h b=%b e=%b o=%b want v=%b d=%h b=%b e=%b o=%b",
                   out_valid, out_digits, out_blank, out_err, overrun,
                   m_valid, m_digits, m_blank, m_err, m_ovr);
        end
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overrun();
    test_simultaneous();
    test_glitch();
    test_blank_invalid();
    test_select_faults();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
